cbus_line_mover: RTL and testbench

CBUS_LINE_MOVER -- requirements
Module: cbus_line_mover

---
 rtl/cbus_line_mover.sv | 169 ++++++++++++++++
 tb/tb_cbus_line_mover.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_line_mover.sv
// Cache-line mover: turns one line read/write command into a single CBus burst,
// gathering read beats into rline or streaming a latched write line out.
package cbus_line_mover_pkg;
  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [2:0] {MLEN_1, MLEN_2, MLEN_4, MLEN_8, MLEN_16} mlen_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic        is_write;
    msize_t      size;
    mlen_t       len;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_line_mover
  import cbus_line_mover_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [63:0]                    cmd_addr,
  input  logic [WORDS_PER_LINE*64-1:0]   wline,
  output logic [WORDS_PER_LINE*64-1:0]   rline,
  output logic                           done,
  output logic                           err,
  output cbus_req_t                      oreq,
  input  cbus_resp_t                     oresp
);

  localparam int unsigned CNT_W     = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFS_W     = $clog2(WORDS_PER_LINE * 8);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [63:0] ADDR_MASK = ~((64'd1 << OFS_W) - 64'd1);
  localparam mlen_t LINE_LEN = (WORDS_PER_LINE == 2) ? MLEN_2 :
                               (WORDS_PER_LINE == 4) ? MLEN_4 :
                               (WORDS_PER_LINE == 8) ? MLEN_8 : MLEN_16;

  typedef enum logic [1:0] {IDLE, RBURST, WBURST, FIN} state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_over, w_over;
  logic [63:0]      r_addr, w_addr;
  logic             r_write, w_write;
  logic [63:0]      r_wline [WORDS_PER_LINE];
  logic [63:0]      r_rline [WORDS_PER_LINE];
  logic             r_cmd_ready, r_done, r_err;
  cbus_req_t        r_oreq, w_oreq;
  logic             w_accept, w_beat, w_err;
  logic [63:0]      w_wdata;

  // Next state, beat bookkeeping and the request image for the coming cycle
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_over   = r_over;
    w_addr   = r_addr;
    w_write  = r_write;
    w_accept = 1'b0;
    w_beat   = 1'b0;
    w_err    = 1'b0;
    w_wdata  = '0;
    w_oreq   = '0;

    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_addr   = cmd_addr & ADDR_MASK;
          w_write  = cmd_write;
          w_cnt    = '0;
          w_over   = 1'b0;
          w_state  = cmd_write ? WBURST : RBURST;
        end
      end
      RBURST, WBURST: begin
        if (oresp.ready) begin
          w_beat = 1'b1;
          // Overlong bursts pin the counter on the last word and poison the result
          if (r_cnt == LAST_IDX) begin
            if (!oresp.last) w_over = 1'b1;
          end else begin
            w_cnt = CNT_W'(r_cnt + 1'b1);
          end
          if (oresp.last) begin
            w_state = FIN;
            w_err   = r_over || (r_cnt != LAST_IDX);
          end
        end
      end
      FIN:     w_state = IDLE;
      default: w_state = IDLE;
    endcase

    w_wdata = w_accept ? wline[63:0] : r_wline[w_cnt];

    if (w_state == RBURST || w_state == WBURST) begin
      w_oreq.valid    = 1'b1;
      w_oreq.addr     = w_addr;
      w_oreq.is_write = w_write;
      w_oreq.size     = MSIZE8;
      w_oreq.len      = LINE_LEN;
      if (w_write) begin
        w_oreq.strobe = 8'hFF;
        w_oreq.data   = w_wdata;
      end
    end
  end

  // State and datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_over      <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_oreq      <= '0;
      for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
        r_wline[i] <= '0;
        r_rline[i] <= '0;
      end
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_over      <= w_over;
      r_addr      <= w_addr;
      r_write     <= w_write;
      r_cmd_ready <= (w_state == IDLE);
      r_done      <= (w_state == FIN);
      r_err       <= w_err;
      r_oreq      <= w_oreq;
      if (w_accept) begin
        for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
          r_wline[i] <= wline[i*64 +: 64];
        end
      end
      if (w_beat && (r_state == RBURST) && !r_over) begin
        r_rline[r_cnt] <= oresp.data;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign done      = r_done;
  assign err       = r_err;
  assign oreq      = r_oreq;

  for (genvar g = 0; g < int'(WORDS_PER_LINE); g++) begin : g_rline
    assign rline[g*64 +: 64] = r_rline[g];
  end

endmodule

// File: tb/tb_cbus_line_mover.sv
// Directed bench for cbus_line_mover: reads, waited writes, short/long bursts,
// mid-burst reset and back-to-back commands against hand-computed values.
module tb_cbus_line_mover;
  import cbus_line_mover_pkg::*;

  localparam int unsigned N = 4;

  logic            clk;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [63:0]     cmd_addr;
  logic [N*64-1:0] wline;
  logic [N*64-1:0] rline;
  logic            done;
  logic            err;
  cbus_req_t       oreq;
  cbus_resp_t      oresp;

  int unsigned n_chk;
  int unsigned n_pass;

  cbus_line_mover #(.WORDS_PER_LINE(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .wline    (wline),
    .rline    (rline),
    .done     (done),
    .err      (err),
    .oreq     (oreq),
    .oresp    (oresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic rdy, input logic lst, input logic [63:0] d);
    oresp.ready = rdy;
    oresp.last  = lst;
    oresp.data  = d;
  endtask

  function automatic logic [63:0] rword(input int k);
    return rline[k*64 +: 64];
  endfunction

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    wline     = '0;
    resp(1'b0, 1'b0, 64'd0);

    // Reset state
    tick();
    tick();
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_err",   64'(err),       64'd0);
    chk("rst_oreq",  64'(|oreq),     64'd0);
    chk("rst_rline", 64'(|rline),    64'd0);
    reset = 1'b1;
    tick();

    // Read, no wait states
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 64'h8000_0014;
    tick();
    cmd_valid = 1'b0;
    chk("rd_addr",   oreq.addr,           64'h8000_0000);
    chk("rd_iswr",   64'(oreq.is_write),  64'd0);
    chk("rd_size",   64'(oreq.size),      64'd3);
    chk("rd_len",    64'(oreq.len),       64'd2);
    chk("rd_strobe", 64'(oreq.strobe),    64'd0);
    chk("rd_busy",   64'(cmd_ready),      64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rd_valid", 64'(oreq.valid), 64'd1);
      chk("rd_addr_hold", oreq.addr, 64'h8000_0000);
      resp(1'b1, (i == 3), 64'h11 * 64'(i + 1));
      tick();
    end
    resp(1'b0, 1'b0, 64'd0);
    chk("rd_done",      64'(done),       64'd1);
    chk("rd_err",       64'(err),        64'd0);
    chk("rd_fin_valid", 64'(oreq.valid), 64'd0);
    chk("rd_fin_ready", 64'(cmd_ready),  64'd0);
    for (int k = 0; k < 4; k++) chk("rd_word", rword(k), 64'h11 * 64'(k + 1));
    tick();
    chk("rd_idle_ready", 64'(cmd_ready), 64'd1);
    chk("rd_idle_done",  64'(done),      64'd0);

    // Write, ready on alternate cycles; wline is trashed after acceptance
    wline     = {64'hD, 64'hC, 64'hB, 64'hA};
    cmd_write = 1'b1;
    cmd_addr  = 64'h1000_0040;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wline     = '1;
    chk("wr_iswr",   64'(oreq.is_write), 64'd1);
    chk("wr_strobe", 64'(oreq.strobe),   64'hFF);
    chk("wr_addr",   oreq.addr,          64'h1000_0040);
    for (int k = 0; k < 4; k++) begin
      chk("wr_data_wait", oreq.data, 64'hA + 64'(k));
      resp(1'b0, 1'b0, 64'd0);
      tick();
      chk("wr_data_beat", oreq.data,        64'hA + 64'(k));
      chk("wr_valid",     64'(oreq.valid),  64'd1);
      chk("wr_done_early", 64'(done),       64'd0);
      resp(1'b1, (k == 3), 64'd0);
      tick();
    end
    resp(1'b0, 1'b0, 64'd0);
    chk("wr_done",   64'(done), 64'd1);
    chk("wr_err",    64'(err),  64'd0);
    chk("wr_rline0", rword(0),  64'h11);
    chk("wr_rline3", rword(3),  64'h44);
    tick();
    chk("wr_idle_ready", 64'(cmd_ready), 64'd1);

    // Early last on beat 1
    cmd_write = 1'b0;
    cmd_addr  = 64'h2000_0000;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    resp(1'b1, 1'b0, 64'hAA);
    tick();
    resp(1'b1, 1'b1, 64'hBB);
    tick();
    resp(1'b0, 1'b0, 64'd0);
    chk("el_done", 64'(done), 64'd1);
    chk("el_err",  64'(err),  64'd1);
    chk("el_w0",   rword(0),  64'hAA);
    chk("el_w1",   rword(1),  64'hBB);
    chk("el_w2",   rword(2),  64'h33);
    chk("el_w3",   rword(3),  64'h44);
    tick();

    // Missing last: six plain beats then a last beat; beats 4..6 dropped
    cmd_addr  = 64'h2000_0080;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("ml_valid", 64'(oreq.valid), 64'd1);
      resp(1'b1, (i == 6), 64'h100 + 64'(i));
      tick();
    end
    resp(1'b0, 1'b0, 64'd0);
    chk("ml_done", 64'(done), 64'd1);
    chk("ml_err",  64'(err),  64'd1);
    for (int k = 0; k < 4; k++) chk("ml_word", rword(k), 64'h100 + 64'(k));
    tick();

    // Reset after beat 1 of a read
    cmd_addr  = 64'h3000_0000;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    resp(1'b1, 1'b0, 64'h55);
    tick();
    resp(1'b1, 1'b0, 64'h66);
    tick();
    reset = 1'b0;
    resp(1'b1, 1'b1, 64'h77);
    tick();
    reset = 1'b1;
    resp(1'b0, 1'b0, 64'd0);
    chk("rm_valid", 64'(oreq.valid), 64'd0);
    chk("rm_ready", 64'(cmd_ready),  64'd1);
    chk("rm_done",  64'(done),       64'd0);
    chk("rm_rline", 64'(|rline),     64'd0);
    tick();
    chk("rm_nodone", 64'(done), 64'd0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("rm2_addr", oreq.addr, 64'h3000_0000);
    for (int i = 0; i < 4; i++) begin
      resp(1'b1, (i == 3), 64'hA1 + 64'(i));
      tick();
    end
    resp(1'b0, 1'b0, 64'd0);
    chk("rm2_done", 64'(done), 64'd1);
    chk("rm2_err",  64'(err),  64'd0);
    for (int k = 0; k < 4; k++) chk("rm2_word", rword(k), 64'hA1 + 64'(k));
    tick();

    // Back-to-back: cmd_valid held through a whole read
    cmd_write = 1'b0;
    cmd_addr  = 64'h4000_0000;
    cmd_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bb_busy", 64'(cmd_ready), 64'd0);
      resp(1'b1, (i == 3), 64'hB0 + 64'(i));
      tick();
    end
    resp(1'b0, 1'b0, 64'd0);
    chk("bb_done",      64'(done),      64'd1);
    chk("bb_fin_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk("bb_idle_ready", 64'(cmd_ready),  64'd1);
    chk("bb_idle_valid", 64'(oreq.valid), 64'd0);
    chk("bb_idle_done",  64'(done),       64'd0);
    chk("bb_w0",         rword(0),        64'hB0);
    chk("bb_w3",         rword(3),        64'hB3);
    tick();
    chk("bb_accept_valid", 64'(oreq.valid), 64'd1);
    chk("bb_accept_ready", 64'(cmd_ready),  64'd0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp(1'b1, (i == 3), 64'hC0 + 64'(i));
      tick();
    end
    resp(1'b0, 1'b0, 64'd0);
    chk("bb2_done", 64'(done), 64'd1);
    chk("bb2_err",  64'(err),  64'd0);
    chk("bb2_w3",   rword(3),  64'hC3);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
